// File: rtl/calcu_a.sv
// Guided-filter a-coefficient stage: a = cov_Ip / (var_I + EPS) in Q7, clamped to [0,1.0].
// Reads var_I (RAM A) and cov_Ip (RAM B) per pixel, writes a to RAM C; fixed 10 cycles per pixel.
module calcu_a #(
  parameter int WIDTH  = 300,
  parameter int HEIGHT = 210,
  parameter int DW     = 24,
  parameter int AW     = 16,
  parameter int EPS    = 1,
  parameter int FRAC   = 7
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          ena,
  output logic          done,
  input  logic [DW-1:0] oDataA,
  input  logic [DW-1:0] oDataB,
  output logic          wrenA,
  output logic          wrenB,
  output logic          wrenC,
  output logic [AW-1:0] iAddrA,
  output logic [AW-1:0] iAddrB,
  output logic [AW-1:0] iAddrC,
  output logic [DW-1:0] iDataC
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
  localparam int IW = $clog2(FRAC + 1);

  typedef enum logic [2:0] {IDLE, RD, LAT, DIV, WR, DONE} state_t;
  typedef enum logic [1:0] {CLS_DIV, CLS_NEG, CLS_SAT} cls_t;

  state_t          state, stateNext;
  cls_t            cls, clsNext;
  logic [AW-1:0]   addr, addrNext;
  logic [DW:0]     denom, denomNext;
  logic [DW+1:0]   rem, remNext;
  logic [FRAC-1:0] quo, quoNext;
  logic [IW-1:0]   iter, iterNext;

  logic [DW:0]     denomIn;
  logic [DW:0]     covExt;
  logic [DW+1:0]   remShift;
  logic [7:0]      aVal;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
      cls   <= CLS_NEG;
      addr  <= '0;
      denom <= '0;
      rem   <= '0;
      quo   <= '0;
      iter  <= '0;
    end else begin
      state <= stateNext;
      cls   <= clsNext;
      addr  <= addrNext;
      denom <= denomNext;
      rem   <= remNext;
      quo   <= quoNext;
      iter  <= iterNext;
    end
  end

  always_comb begin
    stateNext = state;
    clsNext   = cls;
    addrNext  = addr;
    denomNext = denom;
    remNext   = rem;
    quoNext   = quo;
    iterNext  = iter;
    denomIn   = {1'b0, oDataA} + (DW+1)'(EPS);
    covExt    = {1'b0, oDataB};
    remShift  = rem << 1;

    case (state)
      IDLE: begin
        addrNext = '0;
        if (ena) stateNext = RD;
      end
      RD: stateNext = LAT;
      LAT: begin
        denomNext = denomIn;
        quoNext   = '0;
        iterNext  = '0;
        remNext   = '0;
        // Classify up front so the divider only ever sees 0 < cov < denom.
        if (oDataB[DW-1] || oDataB == '0) begin
          clsNext = CLS_NEG;
        end else if (covExt >= denomIn) begin
          clsNext = CLS_SAT;
        end else begin
          clsNext = CLS_DIV;
          remNext = {1'b0, covExt};
        end
        stateNext = DIV;
      end
      DIV: begin
        // Runs the full FRAC cycles regardless of class to keep latency fixed.
        if (remShift >= {1'b0, denom}) begin
          remNext = remShift - {1'b0, denom};
          quoNext = {quo[FRAC-2:0], 1'b1};
        end else begin
          remNext = remShift;
          quoNext = {quo[FRAC-2:0], 1'b0};
        end
        iterNext = iter + 1'b1;
        if (iter == IW'(FRAC - 1)) stateNext = WR;
      end
      WR: begin
        if (addr == LAST) begin
          stateNext = DONE;
        end else begin
          addrNext  = addr + 1'b1;
          stateNext = RD;
        end
      end
      DONE: begin
        addrNext  = '0;
        stateNext = ena ? RD : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    case (cls)
      CLS_SAT: aVal = 8'(1 << FRAC);
      CLS_DIV: aVal = {{(8-FRAC){1'b0}}, quo};
      default: aVal = 8'd0;
    endcase
  end

  assign wrenA  = 1'b0;
  assign wrenB  = 1'b0;
  assign wrenC  = (state == WR);
  assign done   = (state == DONE);
  assign iAddrA = addr;
  assign iAddrB = addr;
  assign iAddrC = addr;
  assign iDataC = (state == WR) ? {{(DW-8){1'b0}}, aVal} : '0;

endmodule

// File: tb/tb_calcu_a.sv
// Scoreboard bench for calcu_a on a 2x1 frame: directed var/cov pairs, frame timing,
// continuous-ena restart and mid-run reset.
module tb_calcu_a;

  localparam int DW = 24;
  localparam int AW = 16;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          ena = 1'b0;
  logic          done;
  logic [DW-1:0] oDataA, oDataB;
  logic          wrenA, wrenB, wrenC;
  logic [AW-1:0] iAddrA, iAddrB, iAddrC;
  logic [DW-1:0] iDataC;

  calcu_a #(.WIDTH(2), .HEIGHT(1), .DW(DW), .AW(AW), .EPS(1), .FRAC(7)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .ena(ena), .done(done),
    .oDataA(oDataA), .oDataB(oDataB),
    .wrenA(wrenA), .wrenB(wrenB), .wrenC(wrenC),
    .iAddrA(iAddrA), .iAddrB(iAddrB), .iAddrC(iAddrC), .iDataC(iDataC)
  );

  always #5 iCLK = ~iCLK;

  logic [DW-1:0] memA [4];
  logic [DW-1:0] memB [4];
  always @(posedge iCLK) begin
    oDataA <= memA[iAddrA[1:0]];
    oDataB <= memB[iAddrB[1:0]];
  end

  int edgeCnt = 0;
  always @(posedge iCLK) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t wrQ[$];
  int   doneQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   monOn = 1'b0;

  // Monitor: the cycle observed after edge e is cycle e+1 in the run's numbering.
  always @(negedge iCLK) begin
    if (monOn) begin
      int cur;
      exp_t e;
      cur = edgeCnt + 1;
      checks++;
      if (wrenA !== 1'b0 || wrenB !== 1'b0) begin
        errors++;
        $display("FAIL wrenAB cycle %0d: wrenA=%b wrenB=%b, required 0 0", cur, wrenA, wrenB);
      end
      checks++;
      if (iAddrA >= 2 || iAddrA !== iAddrB || iAddrA !== iAddrC) begin
        errors++;
        $display("FAIL addr_share cycle %0d: A=%0d B=%0d C=%0d", cur, iAddrA, iAddrB, iAddrC);
      end
      if (wrenC === 1'b1) begin
        checks++;
        if (wrQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cycle %0d: addr=%0d data=%0d, required no write", cur, iAddrC, iDataC);
        end else begin
          e = wrQ.pop_front();
          if (cur != e.cyc || iAddrC !== e.addr || iDataC !== e.data) begin
            errors++;
            $display("FAIL write cycle/addr/data: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     cur, iAddrC, iDataC, e.cyc, e.addr, e.data);
          end else begin
            $display("write ok cycle %0d addr %0d data %0d", cur, iAddrC, iDataC);
          end
        end
      end else begin
        checks++;
        if (iDataC !== '0) begin
          errors++;
          $display("FAIL idle_data cycle %0d: iDataC=%0d, required 0", cur, iDataC);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (doneQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cycle %0d", cur);
        end else begin
          int d;
          d = doneQ.pop_front();
          if (d != cur) begin
            errors++;
            $display("FAIL done_cycle: got %0d, required %0d", cur, d);
          end else begin
            $display("done ok cycle %0d", cur);
          end
        end
      end
    end
  end

  task automatic loadRam(input logic [DW-1:0] v0, c0, v1, c1);
    memA[0] = v0; memB[0] = c0;
    memA[1] = v1; memB[1] = c1;
    memA[2] = '0; memB[2] = '0;
    memA[3] = '0; memB[3] = '0;
  endtask

  // Raises ena for one edge; k is the index of the edge that samples it.
  task automatic pulseEna(output int k);
    @(negedge iCLK);
    ena = 1'b1;
    k = edgeCnt + 1;
    @(negedge iCLK);
    ena = 1'b0;
  endtask

  task automatic expectFrame(input int k, input logic [DW-1:0] a0, a1);
    wrQ.push_back('{cyc: k + 10, addr: 16'd0, data: a0});
    wrQ.push_back('{cyc: k + 20, addr: 16'd1, data: a1});
    doneQ.push_back(k + 21);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((wrQ.size() != 0 || doneQ.size() != 0) && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    checks++;
    if (wrQ.size() != 0 || doneQ.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d writes and %0d dones still pending, required 0", wrQ.size(), doneQ.size());
      wrQ.delete();
      doneQ.delete();
    end
    repeat (3) @(negedge iCLK);
  endtask

  initial begin
    int k;
    loadRam(24'd0, 24'd0, 24'd0, 24'd0);
    repeat (3) @(negedge iCLK);
    // Reset values while iRST_N is still low.
    checks++;
    if (done !== 1'b0 || wrenC !== 1'b0 || iDataC !== '0 || iAddrA !== '0) begin
      errors++;
      $display("FAIL reset_state: done=%b wrenC=%b iDataC=%0d addr=%0d, required 0 0 0 0",
               done, wrenC, iDataC, iAddrA);
    end
    iRST_N = 1'b1;
    monOn = 1'b1;
    repeat (2) @(negedge iCLK);

    // 6400/100 = 64; 128/3 = 42
    loadRam(24'd99, 24'd50, 24'd2, 24'd1);
    pulseEna(k);
    expectFrame(k, 24'd64, 24'd42);
    drain(60);

    // cov=0 with var=0, and negative cov: both 0 with unchanged timing
    loadRam(24'd0, 24'd0, 24'd5, 24'hFFFFFB);
    pulseEna(k);
    expectFrame(k, 24'd0, 24'd0);
    drain(60);

    // Saturation (1000 >= 11) and exact boundary (100 >= 100); ena held across two runs
    loadRam(24'd10, 24'd1000, 24'd99, 24'd100);
    @(negedge iCLK);
    ena = 1'b1;
    k = edgeCnt + 1;
    expectFrame(k, 24'd128, 24'd128);
    wrQ.push_back('{cyc: k + 31, addr: 16'd0, data: 24'd128});
    wrQ.push_back('{cyc: k + 41, addr: 16'd1, data: 24'd128});
    doneQ.push_back(k + 42);
    repeat (25) @(negedge iCLK);
    ena = 1'b0;
    drain(80);

    // Reset during pixel 1 divide: 25600/256 = 100 for pixel 0; 384/7 = 54 after restart
    loadRam(24'd255, 24'd200, 24'd6, 24'd3);
    pulseEna(k);
    wrQ.push_back('{cyc: k + 10, addr: 16'd0, data: 24'd100});
    while (edgeCnt + 1 < k + 14) @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    checks++;
    if (wrenC !== 1'b0 || done !== 1'b0 || iDataC !== '0) begin
      errors++;
      $display("FAIL midrun_reset_out: wrenC=%b done=%b iDataC=%0d, required 0 0 0", wrenC, done, iDataC);
    end
    checks++;
    if (iAddrA !== '0 || iAddrB !== '0 || iAddrC !== '0) begin
      errors++;
      $display("FAIL midrun_reset_addr: A=%0d B=%0d C=%0d, required 0 0 0", iAddrA, iAddrB, iAddrC);
    end
    checks++;
    if (wrQ.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_write: %0d writes missing, required 0", wrQ.size());
      wrQ.delete();
    end
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);
    pulseEna(k);
    expectFrame(k, 24'd100, 24'd54);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
